// File: rtl/ro_sensor_pkg.sv
// Shared definitions for the ring-oscillator temperature sensor slice:
// FSM states, result byte selection codes and the byte-select helper.
package ro_sensor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0]  SEL_LSB       = 2'd0;
  localparam logic [1:0]  SEL_MSB       = 2'd1;
  localparam logic [1:0]  SEL_TERM      = 2'd2;
  localparam logic [7:0]  TERM_BYTE     = 8'h0A;
  localparam int unsigned DEFAULT_SUM_W = 16;

  function automatic logic [7:0] select_byte(input logic [15:0] value,
                                             input logic [1:0]  sel);
    logic [7:0] b;
    b = 8'h00;
    case (sel)
      SEL_LSB:  b = value[7:0];
      SEL_MSB:  b = value[15:8];
      SEL_TERM: b = TERM_BYTE;
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ro_sum_accumulator_if.sv
// Bundle between the RO sum accumulator and the measurement/UART controller.
interface ro_sum_accumulator_if
  import ro_sensor_pkg::*;
#(
  parameter int unsigned SUM_W = DEFAULT_SUM_W
);
  logic             ro_in;
  logic             sum_en;
  logic [1:0]       send_sel;
  logic             sum_ready;
  logic [SUM_W-1:0] sum;
  logic [7:0]       tx_data;

  modport master (
    output ro_in, sum_en, send_sel,
    input  sum_ready, sum, tx_data
  );

  modport slave (
    input  ro_in, sum_en, send_sel,
    output sum_ready, sum, tx_data
  );
endinterface

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus a third flop giving a
// one-cycle pulse on each synchronized 0->1 transition.
module ro_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], async_in};
  end

  assign edge_pulse = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/ro_sum_accumulator.sv
// Counts RO rising edges over NUM_WINDOWS gate windows of GATE_CYCLES clocks,
// publishes the saturating sum with a one-cycle sum_ready pulse.
module ro_sum_accumulator
  import ro_sensor_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned NUM_WINDOWS = 4,
  parameter int unsigned SUM_W       = DEFAULT_SUM_W
) (
  input  logic                   clk,
  input  logic                   reset,
  ro_sum_accumulator_if.slave    bus
);
  localparam int unsigned GW = $clog2(GATE_CYCLES);
  localparam int unsigned WW = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(NUM_WINDOWS - 1);

  state_t           state, state_n;
  logic [GW-1:0]    gate_cnt, gate_cnt_n;
  logic [WW-1:0]    win_cnt, win_cnt_n;
  logic [SUM_W-1:0] acc, acc_n, acc_inc;
  logic [SUM_W-1:0] sum_q, sum_n;
  logic             ready_q, ready_n;
  logic             edge_pulse;

  ro_edge_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (bus.ro_in),
    .edge_pulse (edge_pulse)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gate_cnt <= '0;
      win_cnt  <= '0;
      acc      <= '0;
      sum_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_n;
      gate_cnt <= gate_cnt_n;
      win_cnt  <= win_cnt_n;
      acc      <= acc_n;
      sum_q    <= sum_n;
      ready_q  <= ready_n;
    end
  end

  always_comb begin
    state_n    = state;
    gate_cnt_n = gate_cnt;
    win_cnt_n  = win_cnt;
    acc_n      = acc;
    sum_n      = sum_q;
    ready_n    = 1'b0;
    acc_inc    = (edge_pulse && (acc != '1)) ? acc + 1'b1 : acc;

    case (state)
      IDLE: begin
        gate_cnt_n = '0;
        win_cnt_n  = '0;
        acc_n      = '0;
        if (bus.sum_en) state_n = GATE;
      end
      GATE: begin
        if (!bus.sum_en) begin
          state_n    = IDLE;
          gate_cnt_n = '0;
          win_cnt_n  = '0;
          acc_n      = '0;
        end else begin
          acc_n = acc_inc;
          if (gate_cnt == GATE_LAST) begin
            gate_cnt_n = '0;
            if (win_cnt == WIN_LAST) begin
              // Publish on entry to DONE so sum and the pulse appear together.
              state_n   = DONE;
              win_cnt_n = '0;
              sum_n     = acc_inc;
              ready_n   = 1'b1;
            end else begin
              win_cnt_n = win_cnt + 1'b1;
            end
          end else begin
            gate_cnt_n = gate_cnt + 1'b1;
          end
        end
      end
      DONE: begin
        gate_cnt_n = '0;
        win_cnt_n  = '0;
        acc_n      = '0;
        state_n    = bus.sum_en ? GATE : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.sum       = sum_q;
  assign bus.sum_ready = ready_q;
  assign bus.tx_data   = select_byte(16'(sum_q), bus.send_sel);
endmodule
